// File: rtl/wb_mem_responder_if.sv
// Wishbone B4 pipelined bus between the L1 memory access unit and the memory model.
interface wb_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    stall;
    logic                    ack;
    logic                    err;
    logic [DATA_WIDTH-1:0]   dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output stall, ack, err, dat_r
    );
endinterface

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 memory model: queues requests in a FIFO, services one
// per cycle against a word array, answers in order, optional ack throttling.
module wb_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACK_GAP    = 0
) (
    input  logic     wb_clk_i,
    input  logic     rst_n,
    wb_mem_if.slave  wb
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned SEL_W = DATA_WIDTH / 8;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = (ACK_GAP > 0) ? $clog2(ACK_GAP + 1) : 1;

    // One queued request; range check is resolved at accept time.
    typedef struct packed {
        logic                  we;
        logic                  oor;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] dat;
        logic [SEL_W-1:0]      sel;
    } req_t;

    req_t                  fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem    [MEM_WORDS];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [GAP_W-1:0]      gap_q,    gap_d;
    logic                  ack_q,    ack_d;
    logic                  err_q,    err_d;
    logic [DATA_WIDTH-1:0] dat_q,    dat_d;

    logic                  stall_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  oor_c;
    logic                  mem_we_c;
    req_t                  push_req_c;
    req_t                  head_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  unused_adr_c;

    // Byte offset bits carry no meaning for a word-addressed array.
    assign unused_adr_c = ^wb.adr[1:0];

    assign stall_c  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_c   = wb.cyc & wb.stb & ~stall_c;
    assign pop_c    = wb.cyc & (count_q != '0) & (gap_q == '0);
    assign oor_c    = |(wb.adr >> (IDX_W + 2));
    assign head_c   = fifo_q[rd_ptr_q];

    assign push_req_c = '{we:  wb.we,
                          oor: oor_c,
                          idx: wb.adr[IDX_W+1:2],
                          dat: wb.dat_w,
                          sel: wb.sel};

    assign wb.stall = stall_c;
    assign wb.ack   = ack_q;
    assign wb.err   = err_q;
    assign wb.dat_r = dat_q;

    // Next-state: FIFO bookkeeping, gap throttle, response generation, abort flush.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gap_d    = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        mem_we_c = 1'b0;
        wdata_c  = mem[head_c.idx];

        if (!wb.cyc) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            gap_d    = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                gap_d    = GAP_W'(ACK_GAP);
                if (head_c.oor) begin
                    err_d = 1'b1;
                end else begin
                    ack_d = 1'b1;
                    if (head_c.we) begin
                        mem_we_c = 1'b1;
                        for (int unsigned b = 0; b < SEL_W; b++) begin
                            if (head_c.sel[b]) begin
                                wdata_c[b*8 +: 8] = head_c.dat[b*8 +: 8];
                            end
                        end
                    end else begin
                        dat_d = mem[head_c.idx];
                    end
                end
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and response registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
        end
    end

    // Request FIFO storage; contents are don't-care until counted.
    always_ff @(posedge wb_clk_i) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= push_req_c;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we_c) begin
            mem[head_c.idx] <= wdata_c;
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: one instance with ACK_GAP=0, one with ACK_GAP=3.
module tb_wb_mem_responder;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 1024;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wb_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    wb_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

    wb_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .FIFO_DEPTH(4), .ACK_GAP(0)
    ) dut0 (
        .wb_clk_i(clk),
        .rst_n   (rst_n),
        .wb      (if0)
    );

    wb_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .FIFO_DEPTH(4), .ACK_GAP(3)
    ) dut3 (
        .wb_clk_i(clk),
        .rst_n   (rst_n),
        .wb      (if3)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] r_dat [$];
    int          r_cyc [$];
    int          r_err;
    bit          r_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single request on if0 into an empty queue; samples the response cycle and the one after.
    task automatic do_req0(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic a1, output logic e1,
                           output logic [31:0] d1, output logic a2, output logic e2);
        if0.cyc   = 1'b1;
        if0.stb   = 1'b1;
        if0.we    = we;
        if0.adr   = adr;
        if0.dat_w = dat;
        if0.sel   = sel;
        tick;
        if0.stb = 1'b0;
        tick;
        a1 = if0.ack;
        e1 = if0.err;
        d1 = if0.dat_r;
        tick;
        a2 = if0.ack;
        e2 = if0.err;
    endtask

    // Burst of n requests to consecutive words on if0, holding on stall; records responses.
    task automatic run0(input int n, input bit we, input logic [31:0] base, input logic [31:0] dbase);
        int i = 0;
        bit acc;
        r_dat.delete();
        r_cyc.delete();
        r_err   = 0;
        r_stall = 0;
        if0.cyc = 1'b1;
        if0.we  = we;
        if0.sel = 4'hF;
        for (int c = 0; c < 200 && (r_dat.size() + r_err) < n; c++) begin
            if (i < n) begin
                if0.stb   = 1'b1;
                if0.adr   = base + 32'(4 * i);
                if0.dat_w = dbase + 32'(i);
            end else begin
                if0.stb = 1'b0;
            end
            acc = if0.stb && !if0.stall;
            if (if0.stall) r_stall = 1;
            tick;
            if (acc) i++;
            if (if0.ack) begin
                r_dat.push_back(if0.dat_r);
                r_cyc.push_back(c);
            end
            if (if0.err) r_err++;
        end
        if0.stb = 1'b0;
        check("run0_done", 64'(r_dat.size() + r_err), 64'(n));
        repeat (4) tick;
    endtask

    // Same as run0 but on the throttled instance.
    task automatic run3(input int n, input bit we, input logic [31:0] base, input logic [31:0] dbase);
        int i = 0;
        bit acc;
        r_dat.delete();
        r_cyc.delete();
        r_err   = 0;
        r_stall = 0;
        if3.cyc = 1'b1;
        if3.we  = we;
        if3.sel = 4'hF;
        for (int c = 0; c < 200 && (r_dat.size() + r_err) < n; c++) begin
            if (i < n) begin
                if3.stb   = 1'b1;
                if3.adr   = base + 32'(4 * i);
                if3.dat_w = dbase + 32'(i);
            end else begin
                if3.stb = 1'b0;
            end
            acc = if3.stb && !if3.stall;
            if (if3.stall) r_stall = 1;
            tick;
            if (acc) i++;
            if (if3.ack) begin
                r_dat.push_back(if3.dat_r);
                r_cyc.push_back(c);
            end
            if (if3.err) r_err++;
        end
        if3.stb = 1'b0;
        check("run3_done", 64'(r_dat.size() + r_err), 64'(n));
        repeat (4) tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        a1, e1, a2, e2;
        logic [31:0] d1;
        int          seen;

        rst_n     = 1'b0;
        if0.cyc   = 1'b0; if0.stb = 1'b0; if0.we = 1'b0;
        if0.adr   = '0;   if0.dat_w = '0; if0.sel = '0;
        if3.cyc   = 1'b0; if3.stb = 1'b0; if3.we = 1'b0;
        if3.adr   = '0;   if3.dat_w = '0; if3.sel = '0;

        // Reset state
        repeat (3) tick;
        check("rst_ack",   64'(if0.ack),   64'd0);
        check("rst_err",   64'(if0.err),   64'd0);
        check("rst_dat",   64'(if0.dat_r), 64'd0);
        check("rst_stall", 64'(if0.stall), 64'd0);
        check("rst_stall3",64'(if3.stall), 64'd0);
        rst_n = 1'b1;
        tick;

        // Write then read, pipelined back to back
        if0.cyc = 1'b1; if0.stb = 1'b1; if0.we = 1'b1;
        if0.adr = 32'h40; if0.dat_w = 32'hDEADBEEF; if0.sel = 4'hF;
        tick;
        check("wr_noack_yet", 64'(if0.ack), 64'd0);
        if0.we = 1'b0;
        tick;
        check("wr_ack", 64'(if0.ack), 64'd1);
        if0.stb = 1'b0;
        tick;
        check("rd_ack", 64'(if0.ack), 64'd1);
        check("rd_dat", 64'(if0.dat_r), 64'hDEADBEEF);
        tick;
        check("rd_ack_pulse", 64'(if0.ack), 64'd0);

        // Byte enables; write ack leaves read data untouched
        do_req0(1'b1, 32'h80, 32'h11223344, 4'hF, a1, e1, d1, a2, e2);
        check("be_wr1_ack", 64'(a1), 64'd1);
        do_req0(1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, a1, e1, d1, a2, e2);
        check("be_wr2_ack", 64'(a1), 64'd1);
        check("be_wr_dat_hold", 64'(d1), 64'hDEADBEEF);
        do_req0(1'b0, 32'h80, 32'h0, 4'hF, a1, e1, d1, a2, e2);
        check("be_rd_dat", 64'(d1), 64'h11BB33DD);

        // Out-of-range at exactly MEM_WORDS*4, then last valid word, then normal read
        do_req0(1'b0, 32'(MW * 4), 32'h0, 4'hF, a1, e1, d1, a2, e2);
        check("oor_err", 64'(e1), 64'd1);
        check("oor_ack", 64'(a1), 64'd0);
        check("oor_err_pulse", 64'(e2), 64'd0);
        check("oor_dat_hold", 64'(d1), 64'h11BB33DD);
        do_req0(1'b0, 32'(MW * 4 - 4), 32'h0, 4'hF, a1, e1, d1, a2, e2);
        check("last_word_ack", 64'(a1), 64'd1);
        check("last_word_err", 64'(e1), 64'd0);
        do_req0(1'b0, 32'h42, 32'h0, 4'hF, a1, e1, d1, a2, e2);
        check("after_oor_ack", 64'(a1), 64'd1);
        check("misaligned_dat", 64'(d1), 64'hDEADBEEF);

        // Line fill: preload 0..7 then 8-beat read burst
        run0(8, 1'b1, 32'h100, 32'd0);
        run0(8, 1'b0, 32'h100, 32'd0);
        check("fill_stall", 64'(r_stall), 64'd0);
        if (r_dat.size() == 8) begin
            check("fill_first_lat", 64'(r_cyc[0]), 64'd1);
            check("fill_consecutive", 64'(r_cyc[7] - r_cyc[0]), 64'd7);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("fill_dat%0d", k), 64'(r_dat[k]), 64'(k));
            end
        end

        // Back-pressure on the ACK_GAP=3 instance
        run3(8, 1'b1, 32'h200, 32'hA0);
        run3(8, 1'b0, 32'h200, 32'h0);
        check("bp_stall_seen", 64'(r_stall), 64'd1);
        if (r_dat.size() == 8) begin
            check("bp_first_lat", 64'(r_cyc[0]), 64'd1);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("bp_dat%0d", k), 64'(r_dat[k]), 64'(32'hA0 + k));
            end
            for (int k = 1; k < 8; k++) begin
                check($sformatf("bp_spacing%0d", k), 64'(r_cyc[k] - r_cyc[k-1]), 64'd4);
            end
        end

        // Abort: drop cyc after the first ack with a read still queued
        run0(3, 1'b1, 32'h300, 32'h50);
        if0.cyc = 1'b1; if0.stb = 1'b1; if0.we = 1'b0; if0.adr = 32'h300;
        tick;
        if0.adr = 32'h304;
        tick;
        check("abort_first_ack", 64'(if0.ack), 64'd1);
        check("abort_first_dat", 64'(if0.dat_r), 64'h50);
        if0.cyc = 1'b0; if0.adr = 32'h308;
        tick;
        check("abort_ack_drop", 64'(if0.ack), 64'd0);
        if0.stb = 1'b0;
        if0.cyc = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (if0.ack || if0.err) seen++;
        end
        check("abort_no_stale", 64'(seen), 64'd0);
        do_req0(1'b0, 32'h308, 32'h0, 4'hF, a1, e1, d1, a2, e2);
        check("abort_new_ack", 64'(a1), 64'd1);
        check("abort_new_dat", 64'(d1), 64'h52);
        check("abort_new_pulse", 64'(a2), 64'd0);

        // Reset with two reads pending on the throttled instance
        if3.cyc = 1'b1; if3.stb = 1'b1; if3.we = 1'b0; if3.adr = 32'h200;
        tick;
        if3.adr = 32'h204;
        tick;
        if3.adr = 32'h208;
        tick;
        if3.stb = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack",   64'(if3.ack),   64'd0);
        check("mid_rst_err",   64'(if3.err),   64'd0);
        check("mid_rst_dat",   64'(if3.dat_r), 64'd0);
        check("mid_rst_stall", 64'(if3.stall), 64'd0);
        check("mid_rst_dat0",  64'(if0.dat_r), 64'd0);
        tick;
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (if3.ack || if3.err) seen++;
        end
        check("post_rst_no_stale", 64'(seen), 64'd0);
        run3(1, 1'b0, 32'h204, 32'h0);
        if (r_dat.size() == 1) begin
            check("post_rst_dat3", 64'(r_dat[0]), 64'hA1);
            check("post_rst_lat3", 64'(r_cyc[0]), 64'd1);
        end
        do_req0(1'b0, 32'h40, 32'h0, 4'hF, a1, e1, d1, a2, e2);
        check("post_rst_ack0", 64'(a1), 64'd1);
        check("post_rst_dat0", 64'(d1), 64'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
